alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between two requesters. A three-state FSM (IDLE, EXEC, RESP)
// grants one requester at a time in IDLE. It registers that requester's
// operands, computes the result in EXEC, and then holds the response in RESP
// until the consumer takes it. At most one operation is in flight.
//
// When both requesters are valid, a round-robin pointer picks the winner.
// After each response the pointer moves to the requester that was not served.
//
// Timing: the ready pulse is visible after edge T and the request is accepted
// at edge T+1. o_rsp_valid is high after edge T+2. Best-case throughput is one
// operation every 3 cycles.
//
// Ports
//   clk                  clock; all state updates on the rising edge
//   i_rst                synchronous active-high reset
//   i_reqN_valid         requester N has an operation pending (N = 0, 1)
//   o_reqN_ready         requester N's operation is accepted this cycle
//   i_reqN_a / _b        requester N signed operands
//   i_reqN_op            requester N opcode
//   o_rsp_valid          a result is available (high only in RESP)
//   i_rsp_ready          the consumer takes the result
//   o_rsp_data           result
//   o_rsp_id             requester that issued the result
//   o_rsp_zero           result equals zero
//   o_rsp_err            the opcode was illegal
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic [NB_DATA-1:0] i_req0_a,
    input  logic [NB_DATA-1:0] i_req0_b,
    input  logic [NB_OP-1:0]   i_req0_op,
    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic [NB_DATA-1:0] i_req1_a,
    input  logic [NB_DATA-1:0] i_req1_b,
    input  logic [NB_OP-1:0]   i_req1_op,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic               o_rsp_id,
    output logic               o_rsp_zero,
    output logic               o_rsp_err
);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic               rr_q,       rr_d;
    logic [NB_DATA-1:0] a_q,        a_d;
    logic [NB_DATA-1:0] b_q,        b_d;
    logic [NB_OP-1:0]   op_q,       op_d;
    logic               req_id_q,   req_id_d;
    logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_id_q,   rsp_id_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q,  rsp_err_d;

    logic               grant_valid;
    logic               grant_id;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_err;

    // -------------------------------------------------------------------------
    // Arbitration. A lone valid requester always wins. When both are valid,
    // the round-robin pointer decides.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant_valid = i_req0_valid | i_req1_valid;
        grant_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = rr_q;
        end else if (i_req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Both ready outputs are held low while reset is asserted.
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        if (!i_rst && state_q == ST_IDLE && grant_valid) begin
            o_req0_ready = ~grant_id;
            o_req1_ready = grant_id;
        end
    end

    // -------------------------------------------------------------------------
    // ALU on the registered operands. Shifts use the full unsigned B. Any
    // amount of NB_DATA or more gives sign fill (SRA) or zero (SRL).
    // -------------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SRA: begin
                if (int'(b_q) >= NB_DATA) begin
                    alu_res = {NB_DATA{a_q[NB_DATA-1]}};
                end else begin
                    alu_res = $signed(a_q) >>> b_q;
                end
            end
            OP_SRL: begin
                if (int'(b_q) >= NB_DATA) begin
                    alu_res = '0;
                end else begin
                    alu_res = a_q >> b_q;
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        req_id_d   = req_id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // A granted valid requester always sees ready, so grant_valid
                // alone marks the handshake.
                if (grant_valid) begin
                    a_d      = grant_id ? i_req1_a  : i_req0_a;
                    b_d      = grant_id ? i_req1_b  : i_req0_b;
                    op_d     = grant_id ? i_req1_op : i_req0_op;
                    req_id_d = grant_id;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_res;
                rsp_zero_d = (alu_res == '0);
                rsp_err_d  = alu_err;
                rsp_id_d   = req_id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rr_d    = ~rsp_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // NOTE: the operand registers are pure datapath. They are always written
    // in IDLE before EXEC reads them, so they need no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        op_q     <= op_d;
        req_id_q <= req_id_d;
    end

    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_zero  = rsp_zero_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter with NB_DATA=8. Inputs are driven 1 ns after
// the rising edge. Outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_req0_valid, i_req1_valid;
    logic       o_req0_ready, o_req1_ready;
    logic [7:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [5:0] i_req0_op, i_req1_op;
    logic       o_rsp_valid, i_rsp_ready;
    logic [7:0] o_rsp_data;
    logic       o_rsp_id, o_rsp_zero, o_rsp_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NB_DATA(8), .NB_OP(6)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .i_req0_op    (i_req0_op),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .i_req1_op    (i_req1_op),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_zero   (o_rsp_zero),
        .o_rsp_err    (o_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] op);
        if (id) begin
            i_req1_valid = 1'b1; i_req1_a = a; i_req1_b = b; i_req1_op = op;
        end else begin
            i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b; i_req0_op = op;
        end
    endtask

    // Runs one operation from IDLE with a single requester and i_rsp_ready=1.
    // The task is entered 1 ns after an edge, with the DUT in IDLE.
    task automatic run_op(input string tag, input logic id, input logic [7:0] a,
                          input logic [7:0] b, input logic [5:0] op,
                          input logic [7:0] exp_data, input logic exp_zero,
                          input logic exp_err);
        i_rsp_ready = 1'b1;
        drive_req(id, a, b, op);
        #1;
        check({tag, ".ready"}, id ? o_req1_ready : o_req0_ready, 1'b1);
        check({tag, ".other_ready"}, id ? o_req0_ready : o_req1_ready, 1'b0);
        tick();                                  // accepted here
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        #1;
        check({tag, ".exec_valid"}, o_rsp_valid, 1'b0);
        tick();                                  // RESP
        check({tag, ".valid"}, o_rsp_valid, 1'b1);
        check({tag, ".data"},  o_rsp_data,  exp_data);
        check({tag, ".zero"},  o_rsp_zero,  exp_zero);
        check({tag, ".err"},   o_rsp_err,   exp_err);
        check({tag, ".id"},    o_rsp_id,    id);
        tick();                                  // consumed, back in IDLE
        check({tag, ".done_valid"}, o_rsp_valid, 1'b0);
        check({tag, ".retain"},     o_rsp_data,  exp_data);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req0_valid = 1'b0; i_req0_a = '0; i_req0_b = '0; i_req0_op = '0;
        i_req1_valid = 1'b0; i_req1_a = '0; i_req1_b = '0; i_req1_op = '0;
        i_rsp_ready  = 1'b1;

        // ---- Reset with both requesters valid; streaming arbitration ----
        drive_req(1'b0, 8'd1, 8'd2, ADD);        // 1 + 2 = 3
        drive_req(1'b1, 8'd9, 8'd4, SUB);        // 9 - 4 = 5
        tick();
        tick();
        check("rst.ready0", o_req0_ready, 1'b0);
        check("rst.ready1", o_req1_ready, 1'b0);
        check("rst.valid",  o_rsp_valid,  1'b0);
        check("rst.data",   o_rsp_data,   8'h00);
        check("rst.id",     o_rsp_id,     1'b0);
        check("rst.zero",   o_rsp_zero,   1'b0);
        check("rst.err",    o_rsp_err,    1'b0);
        i_rst = 1'b0;
        // The first operation is granted in cycle k=0. Each operation takes
        // 3 cycles, and ids alternate 0,1,0,1.
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("rr.k%0d.ready0", k), o_req0_ready,
                  (k % 3 == 0) && ((k / 3) % 2 == 0));
            check($sformatf("rr.k%0d.ready1", k), o_req1_ready,
                  (k % 3 == 0) && ((k / 3) % 2 == 1));
            check($sformatf("rr.k%0d.valid", k), o_rsp_valid, k % 3 == 2);
            if (k % 3 == 2) begin
                check($sformatf("rr.k%0d.id", k), o_rsp_id, (k / 3) % 2);
                check($sformatf("rr.k%0d.data", k), o_rsp_data,
                      ((k / 3) % 2 == 1) ? 8'd5 : 8'd3);
            end
            @(posedge clk);
        end
        #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        do_reset();

        // ---- Single requests, ALU functions ----
        run_op("add",  1'b0, 8'h03, 8'hFB, ADD, 8'hFE, 1'b0, 1'b0);
        run_op("sub0", 1'b1, 8'h05, 8'h05, SUB, 8'h00, 1'b1, 1'b0);
        run_op("subw", 1'b0, 8'h80, 8'h01, SUB, 8'h7F, 1'b0, 1'b0);
        run_op("addw", 1'b1, 8'hFF, 8'h02, ADD, 8'h01, 1'b0, 1'b0);
        run_op("and",  1'b0, 8'hCC, 8'hAA, AND, 8'h88, 1'b0, 1'b0);
        run_op("or",   1'b1, 8'hC0, 8'h0A, OR,  8'hCA, 1'b0, 1'b0);
        run_op("sra2", 1'b0, 8'hF8, 8'h02, SRA, 8'hFE, 1'b0, 1'b0);
        run_op("srl2", 1'b1, 8'hF8, 8'h02, SRL, 8'h3E, 1'b0, 1'b0);
        run_op("sra9", 1'b0, 8'h80, 8'h09, SRA, 8'hFF, 1'b0, 1'b0);
        run_op("srl9", 1'b0, 8'h80, 8'h09, SRL, 8'h00, 1'b1, 1'b0);
        run_op("sra7", 1'b1, 8'h40, 8'h07, SRA, 8'h00, 1'b1, 1'b0);
        run_op("nor",  1'b0, 8'h0F, 8'hF0, NOR, 8'h00, 1'b1, 1'b0);
        run_op("ill",  1'b1, 8'h12, 8'h34, BAD, 8'h00, 1'b1, 1'b1);

        // ---- Backpressure: i_rsp_ready low for 5 cycles in RESP ----
        i_rsp_ready = 1'b0;
        drive_req(1'b0, 8'h10, 8'h20, ADD);      // 0x30
        #1;
        check("bp.ready0", o_req0_ready, 1'b1);
        tick();                                  // accepted
        i_req0_valid = 1'b0;
        drive_req(1'b1, 8'h05, 8'h05, SUB);      // waits behind req0
        #1;
        check("bp.exec_ready1", o_req1_ready, 1'b0);
        tick();                                  // RESP
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.c%0d.valid", i),  o_rsp_valid,  1'b1);
            check($sformatf("bp.c%0d.data", i),   o_rsp_data,   8'h30);
            check($sformatf("bp.c%0d.ready0", i), o_req0_ready, 1'b0);
            check($sformatf("bp.c%0d.ready1", i), o_req1_ready, 1'b0);
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        check("bp.last.valid",  o_rsp_valid,  1'b1);
        check("bp.last.ready1", o_req1_ready, 1'b0);
        tick();                                  // IDLE again
        check("bp.idle.valid",  o_rsp_valid,  1'b0);
        check("bp.idle.ready1", o_req1_ready, 1'b1);
        tick();                                  // req1 accepted
        i_req1_valid = 1'b0;
        tick();
        check("bp.r1.valid", o_rsp_valid, 1'b1);
        check("bp.r1.data",  o_rsp_data,  8'h00);
        check("bp.r1.zero",  o_rsp_zero,  1'b1);
        check("bp.r1.id",    o_rsp_id,    1'b1);
        tick();

        // ---- Reset pulsed during EXEC discards the operation ----
        drive_req(1'b0, 8'h01, 8'h01, ADD);
        tick();                                  // accepted, now in EXEC
        i_req0_valid = 1'b0;
        i_rst        = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rx.c%0d.valid", i), o_rsp_valid, 1'b0);
            check($sformatf("rx.c%0d.data", i),  o_rsp_data,  8'h00);
            @(posedge clk);
        end
        #1;
        run_op("rx.next", 1'b1, 8'h0F, 8'h3C, XOR, 8'h33, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
